stage3_prefetch_buffer: RTL and testbench
=========================================

// Module: stage3_prefetch_buffer
// PURPOSE
// Sequential instruction prefetcher between the stage3 fetch stage's instruction bus port and the
// memory-side generic bus. Runs ahead of the fetch PC, filling a small FIFO with consecutive words,
// so straight-line fetches complete with zero wait. Discards stale words on redirect or flush.
// Never prefetches past a faulting word or a page boundary.
// PARAMETERS
// RESET_PC    32'h80000000  initial prefetch address
// DEPTH       4             FIFO entries; power of 2, >= 2
// PAGE_BYTES  4096          speculative-issue boundary; power of 2
// PORTS
// CLK        in   1   clock
// nRST       in   1   synchronous active-low reset
// flush      in   1   discard all buffered and in-flight data (hazard-unit redirect)
// f_addr     in   32  fetch-side request address
// f_ren      in   1   fetch-side read request
// f_rdata    out  32  instruction word; valid when f_ren & !f_busy
// f_busy     out  1   fetch-side wait
// f_error    out  1   bus error for returned word; qualified like f_rdata
// m_addr     out  32  memory-side address, word aligned
// m_ren      out  1   memory-side read request; held until m_busy low
// m_wen      out  1   constant 0
// m_byte_en  out  4   constant 4'b1111
// m_rdata    in   32  memory read data; valid when m_ren & !m_busy
// m_busy     in   1   memory wait
// m_error    in   1   memory bus error; qualified like m_rdata
// BEHAVIOUR
// - Clock/reset: single clock CLK; reset nRST is synchronous and active-low.
// - Reset: state IDLE, FIFO empty (count=0, rd/wr ptr=0), issue_addr=RESET_PC, m_ren=0, f_busy=1, f_error=0.
// - FIFO entry = {data[31:0], err}. head_addr = word address of the entry at the read pointer.
// - Address compare uses bits [31:2] only. Alignment faults are detected by the fetch stage.
// - HIT: f_ren & count>0 & f_addr[31:2]==head_addr[31:2] -> f_busy=0 in the same cycle.
//   f_rdata/f_error come from the head entry; pop; head_addr += 4.
// - BYPASS: f_ren & count==0 & state ISSUE & m_addr matches & !m_busy -> forward m_rdata/m_error
//   combinationally with f_busy=0; no push.
// - MISS: f_ren with no hit or bypass-match -> clear FIFO; issue_addr = {f_addr[31:2],2'b00}; f_busy=1.
//   With a request in flight, go to DISCARD; otherwise go to ISSUE next cycle.
// - States:
//   IDLE: m_ren=0. Go to ISSUE when count<DEPTH, no HALT condition, and issue_addr is within the
//     current page.
//   ISSUE: m_ren=1, m_addr=issue_addr. On !m_busy: push {m_rdata,m_error} (unless bypassed),
//     issue_addr += 4. Next state is HALT if m_error; IDLE if count_next==DEPTH or the next issue_addr
//     crosses a PAGE_BYTES boundary; otherwise stay in ISSUE (back-to-back requests).
//   DISCARD: m_ren=1 with m_addr frozen (the generic bus cannot abort). On !m_busy: drop data, go to ISSUE
//     at the redirected issue_addr.
//   HALT: m_ren=0 until MISS or flush. A sequential HIT on the error entry returns f_error=1.
// - flush: same cycle, clear FIFO and block any HIT that cycle. If ISSUE with m_busy=1 -> DISCARD;
//   otherwise -> IDLE. Restart requires a MISS, which supplies the new address.
// - Page-boundary stop: a later sequential f_addr in the next page misses and restarts issue from there.
// - Full: never issue when count==DEPTH. Same-cycle push+pop leaves count unchanged; pointers wrap mod DEPTH.
// - MISS and flush in the same cycle: flush clears; MISS supplies issue_addr.
// - Reset asserted mid-transaction: state returns to reset values immediately; m_ren drops.
// - Latency: a hit costs 0 wait cycles. A miss costs 1 cycle + memory latency (bypass), plus the DISCARD
//   drain when one is pending.
// STRUCTURE
// - Package stage3_prefetch_pkg: pf_state_t enum {IDLE,ISSUE,DISCARD,HALT}; pf_entry_t struct {data,err}.
// - One sub-module, stage3_prefetch_fifo: synchronous FIFO, DEPTH x pf_entry_t, with push/pop/clear and count.
//   Controller and address logic stay in the top module.
// TESTING
// - Reset, f_ren @0x80000000, memory latency 2: first word via bypass at cycle 3. FIFO then fills
//   0x80000004..0x80000010. Sequential f_addr gets f_busy=0 with zero wait.
// - DEPTH=4, f_ren=0: exactly 4 requests issued, then m_ren=0. One pop -> exactly one new request.
//   Simultaneous push+pop keeps count at its value.
// - Buffer holds 0x80000004..0x8000000C, f_addr=0x80002000: FIFO cleared; in-flight 0x80000010 completes in
//   DISCARD and is dropped; next m_addr=0x80002000; no stale word returned.
// - flush while m_busy=1 on 0x80000008: m_ren held at 0x80000008 until !m_busy; data dropped; m_ren=0 until next miss.
// - m_error on 0x80000008: entry stored with err; no request to 0x8000000C.
//   f_addr 0x80000008 -> f_error=1, f_busy=0; a later miss to 0x80000100 resumes.
// - Start at 0x80000FF8: requests stop after 0x80000FFC. f_addr 0x80001000 misses and issues 0x80001000.
//   nRST low mid-ISSUE -> m_ren=0 and count=0 next edge.

Source files
------------

// File: rtl/stage3_prefetch_pkg.sv
// Shared types for the stage3 instruction prefetcher: controller states and
// the FIFO entry layout (instruction word plus bus-error flag).
package stage3_prefetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DISCARD,
    HALT
  } pf_state_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } pf_entry_t;

  localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/stage3_prefetch_fifo.sv
// Synchronous FIFO of prefetched entries with push, pop, clear and occupancy count.
// Clear wins over a same-cycle push; pointers wrap naturally because DEPTH is a power of 2.
module stage3_prefetch_fifo
  import stage3_prefetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  pf_entry_t     push_entry,
  output pf_entry_t     head_entry,
  output logic [CW-1:0] count
);

  pf_entry_t     mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0) && !clear;
    do_push  = push && !clear && ((count_q != CW'(DEPTH)) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head_entry = mem_q[rd_ptr_q];
  assign count      = count_q;

endmodule

// File: rtl/stage3_prefetch_buffer.sv
// Sequential instruction prefetcher between the fetch stage and the memory bus.
// Runs ahead of the fetch PC; never speculates past a faulting word or a page boundary.
module stage3_prefetch_buffer
  import stage3_prefetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int          DEPTH      = 4,
  parameter int          PAGE_BYTES = 4096
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        flush,
  input  logic [31:0] f_addr,
  input  logic        f_ren,
  output logic [31:0] f_rdata,
  output logic        f_busy,
  output logic        f_error,
  output logic [31:0] m_addr,
  output logic        m_ren,
  output logic        m_wen,
  output logic [3:0]  m_byte_en,
  input  logic [31:0] m_rdata,
  input  logic        m_busy,
  input  logic        m_error
);

  localparam int          CW        = $clog2(DEPTH) + 1;
  localparam logic [31:0] PAGE_MASK = 32'(PAGE_BYTES - 1);

  pf_state_t     state_q, state_d;
  logic [31:0]   issue_addr_q, issue_addr_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic          stop_q, stop_d;
  logic [31:0]   head_addr, next_issue_addr;
  logic [CW-1:0] count, count_next;
  pf_entry_t     head_entry, push_entry;
  logic          hit, bypass_match, bypass, miss, clear, push, pop, in_flight;
  logic          unused_addr_bits;

  // head_addr falls out of the invariant that the FIFO holds the words just below issue_addr.
  assign head_addr        = issue_addr_q - (32'(count) << 2);
  assign next_issue_addr  = issue_addr_q + WORD_BYTES;
  assign unused_addr_bits = ^{f_addr[1:0], head_addr[1:0]};

  always_comb begin
    m_ren        = (state_q == ISSUE) || (state_q == DISCARD);
    m_addr       = (state_q == DISCARD) ? req_addr_q : issue_addr_q;
    m_wen        = 1'b0;
    m_byte_en    = 4'b1111;
    in_flight    = m_ren && m_busy;

    hit          = f_ren && !flush && (count != '0) && (f_addr[31:2] == head_addr[31:2]);
    bypass_match = f_ren && !flush && (count == '0) && (state_q == ISSUE) &&
                   (f_addr[31:2] == issue_addr_q[31:2]);
    bypass       = bypass_match && !m_busy;
    miss         = f_ren && !hit && !bypass_match;
    clear        = miss || flush;
    pop          = hit;
    push         = (state_q == ISSUE) && !m_busy && !bypass && !clear;
    push_entry   = '{data: m_rdata, err: m_error};
    count_next   = count + CW'(push) - CW'(pop);

    f_busy       = !(hit || bypass);
    f_rdata      = bypass ? m_rdata : head_entry.data;
    f_error      = hit ? head_entry.err : (bypass ? m_error : 1'b0);

    state_d      = state_q;
    issue_addr_d = issue_addr_q;
    req_addr_d   = req_addr_q;
    stop_d       = stop_q;
    if (state_q == ISSUE) req_addr_d = issue_addr_q;

    case (state_q)
      IDLE: begin
        if (!stop_q && (count < CW'(DEPTH))) state_d = ISSUE;
      end
      ISSUE: begin
        if (!m_busy) begin
          issue_addr_d = next_issue_addr;
          if (m_error) begin
            state_d = HALT;
          end else if ((next_issue_addr & PAGE_MASK) == 32'd0) begin
            state_d = IDLE;
            stop_d  = 1'b1;
          end else if (count_next == CW'(DEPTH)) begin
            state_d = IDLE;
          end
        end
      end
      DISCARD: begin
        if (!m_busy) state_d = stop_q ? IDLE : ISSUE;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase

    // A redirect overrides normal sequencing; only a miss supplies a restart address.
    if (clear) begin
      state_d      = in_flight ? DISCARD : IDLE;
      issue_addr_d = issue_addr_q;
      stop_d       = 1'b1;
      if (miss) begin
        issue_addr_d = {f_addr[31:2], 2'b00};
        stop_d       = 1'b0;
        if (!in_flight) state_d = ISSUE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= IDLE;
      issue_addr_q <= RESET_PC;
      req_addr_q   <= RESET_PC;
      stop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_addr_q <= issue_addr_d;
      req_addr_q   <= req_addr_d;
      stop_q       <= stop_d;
    end
  end

  stage3_prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (CLK),
    .rst_n      (nRST),
    .clear      (clear),
    .push       (push),
    .pop        (pop),
    .push_entry (push_entry),
    .head_entry (head_entry),
    .count      (count)
  );

endmodule

// File: tb/tb_stage3_prefetch_buffer.sv
// Self-checking bench for stage3_prefetch_buffer: a latency-configurable memory model,
// a fetch scoreboard, a vector table for streaming hits and hand-written corner sequences.
module tb_stage3_prefetch_buffer;

  typedef struct {
    logic [31:0] addr;
    int          exp_wait;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk;
  logic        nRST;
  logic        flush;
  logic [31:0] f_addr;
  logic        f_ren;
  logic [31:0] f_rdata;
  logic        f_busy;
  logic        f_error;
  logic [31:0] m_addr;
  logic        m_ren;
  logic        m_wen;
  logic [3:0]  m_byte_en;
  logic [31:0] m_rdata;
  logic        m_busy;
  logic        m_error;

  int          lat;
  int          wait_cnt;
  logic        force_busy;
  logic        err_en;
  logic [31:0] err_addr;
  logic [31:0] req_log [$];
  exp_t        exp_q [$];
  vec_t        stream_tbl [12];
  vec_t        err_tbl [2];
  int          checks;
  int          errors;
  int          w;

  stage3_prefetch_buffer dut (
    .CLK       (clk),
    .nRST      (nRST),
    .flush     (flush),
    .f_addr    (f_addr),
    .f_ren     (f_ren),
    .f_rdata   (f_rdata),
    .f_busy    (f_busy),
    .f_error   (f_error),
    .m_addr    (m_addr),
    .m_ren     (m_ren),
    .m_wen     (m_wen),
    .m_byte_en (m_byte_en),
    .m_rdata   (m_rdata),
    .m_busy    (m_busy),
    .m_error   (m_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hA5C3_0F96;
  endfunction

  // Memory model: each request waits `lat` busy cycles, then completes for one cycle.
  assign m_busy  = force_busy || (m_ren && (wait_cnt != 0));
  assign m_rdata = mem_word(m_addr);
  assign m_error = err_en && m_ren && (m_addr[31:2] == err_addr[31:2]);

  always @(posedge clk) begin
    if (!nRST || !m_ren) wait_cnt <= lat;
    else if (m_busy) begin
      if (wait_cnt != 0) wait_cnt <= wait_cnt - 1;
    end else wait_cnt <= lat;
    if (nRST && m_ren && !m_busy) req_log.push_back(m_addr);
  end

  function automatic logic [31:0] logAt(input int i);
    if (i < 0 || i >= req_log.size()) return 32'hDEAD_BEEF;
    return req_log[i];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual %h, required %h", name, act, req);
    end
  endtask

  // Starts and ends on a falling edge; the fetch request is presented in the calling cycle.
  task automatic applyStimulus(input logic [31:0] addr, input logic exp_err, input int budget,
                               output int waits);
    exp_t e;
    exp_t got;
    logic done;
    e.data = mem_word(addr);
    e.err  = exp_err;
    exp_q.push_back(e);
    waits = 0;
    done  = 1'b0;
    f_addr = addr;
    f_ren  = 1'b1;
    while (!done && waits <= budget) begin
      #1;
      if (!f_busy) done = 1'b1;
      else begin
        waits++;
        @(negedge clk);
      end
    end
    got = exp_q.pop_front();
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL fetch_timeout: actual f_busy stuck for %0d cycles, required completion at %h",
               waits, addr);
      f_ren = 1'b0;
    end else begin
      checkOutput("fetch_data", f_rdata, got.data);
      checkOutput("fetch_err", 32'(f_error), 32'(got.err));
      @(negedge clk);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      f_ren = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic doReset();
    nRST = 1'b0;
    f_ren = 1'b0;
    flush = 1'b0;
    force_busy = 1'b0;
    repeat (3) @(negedge clk);
    req_log.delete();
    nRST = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nRST = 1'b0;
    flush = 1'b0;
    f_ren = 1'b0;
    f_addr = '0;
    force_busy = 1'b0;
    err_en = 1'b0;
    err_addr = 32'h8000_0008;
    lat = 2;
    for (int i = 0; i < 12; i++) stream_tbl[i] = '{32'h8000_0008 + 32'(4 * i), 0, 1'b0};
    err_tbl[0] = '{32'h8000_0004, 0, 1'b0};
    err_tbl[1] = '{32'h8000_0008, 0, 1'b1};
    @(negedge clk);

    $display("[TB] sequence A: reset, bypass, fill, streaming hits");
    doReset();
    #1;
    checkOutput("reset_m_ren", 32'(m_ren), 32'd0);
    checkOutput("reset_f_busy", 32'(f_busy), 32'd1);
    checkOutput("reset_f_error", 32'(f_error), 32'd0);
    checkOutput("const_m_wen", 32'(m_wen), 32'd0);
    checkOutput("const_byte_en", 32'(m_byte_en), 32'hF);
    applyStimulus(32'h8000_0000, 1'b0, 40, w);
    checkOutput("first_bypass_wait", 32'(w), 32'd3);
    idleCycles(20);
    checkOutput("fill_req_count", 32'(req_log.size()), 32'd5);
    checkOutput("fill_last_addr", logAt(4), 32'h8000_0010);
    checkOutput("full_m_ren", 32'(m_ren), 32'd0);
    applyStimulus(32'h8000_0004, 1'b0, 40, w);
    checkOutput("hit_wait", 32'(w), 32'd0);
    idleCycles(20);
    checkOutput("one_pop_one_req", 32'(req_log.size()), 32'd6);
    checkOutput("refill_addr", logAt(5), 32'h8000_0014);
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(stream_tbl[i].addr, stream_tbl[i].exp_err, 40, w);
      checkOutput("stream_wait", 32'(w), 32'(stream_tbl[i].exp_wait));
    end
    idleCycles(20);
    checkOutput("stream_last_req", logAt(req_log.size() - 1), 32'h8000_0044);
    checkOutput("stream_idle_m_ren", 32'(m_ren), 32'd0);

    $display("[TB] sequence B: redirect with a request in flight");
    lat = 2;
    doReset();
    applyStimulus(32'h8000_0000, 1'b0, 40, w);
    idleCycles(10);
    applyStimulus(32'h8000_2000, 1'b0, 40, w);
    checkOutput("redirect_wait", 32'(w), 32'd4);
    checkOutput("discard_addr", logAt(4), 32'h8000_0010);
    checkOutput("redirect_addr", logAt(5), 32'h8000_2000);
    applyStimulus(32'h8000_2004, 1'b0, 40, w);
    checkOutput("redirect_next_wait", 32'(w), 32'd2);

    $display("[TB] sequence C: flush while busy");
    doReset();
    applyStimulus(32'h8000_0000, 1'b0, 40, w);
    idleCycles(4);
    flush = 1'b1;
    force_busy = 1'b1;
    #1;
    checkOutput("flush_cycle_addr", m_addr, 32'h8000_0008);
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checkOutput("discard_m_ren", 32'(m_ren), 32'd1);
      checkOutput("discard_hold_addr", m_addr, 32'h8000_0008);
      @(negedge clk);
    end
    force_busy = 1'b0;
    @(negedge clk);
    idleCycles(10);
    checkOutput("flush_req_count", 32'(req_log.size()), 32'd3);
    checkOutput("flush_idle_m_ren", 32'(m_ren), 32'd0);
    applyStimulus(32'h8000_0004, 1'b0, 40, w);
    checkOutput("flush_refetch_wait", 32'(w), 32'd3);

    $display("[TB] sequence D: bus error halts prefetch");
    lat = 1;
    err_en = 1'b1;
    doReset();
    applyStimulus(32'h8000_0000, 1'b0, 40, w);
    checkOutput("err_first_wait", 32'(w), 32'd2);
    idleCycles(10);
    checkOutput("halt_req_count", 32'(req_log.size()), 32'd3);
    checkOutput("halt_m_ren", 32'(m_ren), 32'd0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(err_tbl[i].addr, err_tbl[i].exp_err, 40, w);
      checkOutput("err_tbl_wait", 32'(w), 32'(err_tbl[i].exp_wait));
    end
    applyStimulus(32'h8000_0100, 1'b0, 40, w);
    checkOutput("resume_wait", 32'(w), 32'd2);
    idleCycles(20);
    checkOutput("resume_last_req", logAt(req_log.size() - 1), 32'h8000_0110);
    err_en = 1'b0;

    $display("[TB] sequence E: page boundary and reset mid-issue");
    doReset();
    applyStimulus(32'h8000_0FF8, 1'b0, 40, w);
    checkOutput("page_first_wait", 32'(w), 32'd2);
    idleCycles(10);
    checkOutput("page_req_count", 32'(req_log.size()), 32'd2);
    checkOutput("page_last_req", logAt(1), 32'h8000_0FFC);
    checkOutput("page_m_ren", 32'(m_ren), 32'd0);
    applyStimulus(32'h8000_0FFC, 1'b0, 40, w);
    checkOutput("page_hit_wait", 32'(w), 32'd0);
    idleCycles(5);
    checkOutput("page_stay_stopped", 32'(req_log.size()), 32'd2);
    applyStimulus(32'h8000_1000, 1'b0, 40, w);
    checkOutput("next_page_wait", 32'(w), 32'd2);
    checkOutput("next_page_req", logAt(2), 32'h8000_1000);
    idleCycles(2);
    nRST = 1'b0;
    #1;
    checkOutput("pre_reset_m_ren", 32'(m_ren), 32'd1);
    @(negedge clk);
    #1;
    checkOutput("mid_reset_m_ren", 32'(m_ren), 32'd0);
    @(negedge clk);
    req_log.delete();
    nRST = 1'b1;
    idleCycles(20);
    checkOutput("post_reset_req_count", 32'(req_log.size()), 32'd4);
    checkOutput("post_reset_first_req", logAt(0), 32'h8000_0000);
    checkOutput("post_reset_last_req", logAt(3), 32'h8000_000C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
